scratch_mem128: RTL and testbench
=================================

SCRATCH_MEM128 -- requirements
Module: scratch_mem128

Interface
REQ-001 Parameter ADR_W, default 18, byte-address width; memory holds 2^ADR_W bytes (256 KiB).
REQ-002 Parameter TID_W, default 13, transaction-ID width.
REQ-003 Port clk_i  in  1  single clock; all state is updated on the rising edge.
REQ-004 Port rst_i  in  1  reset; asynchronous and active-low.
REQ-005 Port cs_i  in  1  chip select; qualifies cyc_i/stb_i.
REQ-006 Port cyc_i  in  1  bus cycle active.
REQ-007 Port stb_i  in  1  strobe; request valid.
REQ-008 Port we_i  in  1  1=write, 0=read.
REQ-009 Port cti_i  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst.
REQ-010 Port sel_i  in  16  byte enables; bit n selects dat_i[8n+7:8n].
REQ-011 Port adr_i  in  ADR_W  byte address; line index is adr_i[ADR_W-1:4], and adr_i[3:0] is ignored.
REQ-012 Port dat_i  in  128  write data.
REQ-013 Port tid_i  in  TID_W  request transaction ID.
REQ-014 Port ip, sp  in  32 each  debug-only inputs; they have no functional effect.
REQ-015 Port dat_o  out  128  read data.
REQ-016 Port ack_o  out  1  transfer acknowledge.
REQ-017 Port next_o  out  1  burst advance strobe.
REQ-018 Port tid_o  out  TID_W  echoed transaction ID.

Function
REQ-019 The storage SHALL be 2^(ADR_W-4) lines of 128 bits each; the storage is not reset.
REQ-020 A request is accepted on an edge where cs_i&cyc_i&stb_i=1 and ack_o=0.
REQ-021 On acceptance, ack_o SHALL be 1 from the next cycle and SHALL hold while cs_i&cyc_i&stb_i remains 1.
REQ-022 ack_o SHALL clear one cycle after stb_i, cyc_i or cs_i falls.
REQ-023 There SHALL be one access per acceptance.
REQ-024 Read: dat_o SHALL equal the addressed line, registered, and valid for the same cycles as ack_o.
REQ-025 Write: on acceptance, each byte with sel_i[n]=1 SHALL be written; bytes with sel_i[n]=0 SHALL be unchanged; sel_i=0 writes nothing but is still acknowledged.
REQ-026 During a write ack, dat_o SHALL hold its previous value.
REQ-027 tid_o SHALL register tid_i at acceptance and hold it until the next acceptance.
REQ-028 A read issued after a write to the same line SHALL return the written data.
REQ-029 Address wrap: lines are indexed modulo 2^(ADR_W-4); there is no error response.
REQ-030 Reset asserted mid-transfer SHALL abort the transfer; a write takes effect only if its acceptance edge preceded reset.

Reset
REQ-031 While rst_i=0: ack_o=0, next_o=0, tid_o=0, dat_o=0, and the internal burst address = 0.
REQ-032 The first acceptance SHALL be possible on the first rising edge after rst_i rises.

Configuration
REQ-033 Macro SCRATCHMEM_BURST_EN defined, burst handling:
- A request accepted with cti_i=010 SHALL start a burst.
- Each subsequent cycle with stb_i=1 SHALL perform one beat at line index +1 (wrapping), with ack_o held at 1.
- next_o SHALL be 1 in each cycle in which a further beat will be performed.
- A beat presented with cti_i=111 SHALL be the last beat; next_o SHALL then be 0 and ack_o SHALL clear on the following cycle.
- Writes in a burst SHALL use the sel_i and dat_i present at each beat.
REQ-034 Macro SCRATCHMEM_BURST_EN undefined:
- next_o SHALL be tied to 0.
- cti_i SHALL be ignored; every transfer behaves as classic.

Verification
REQ-035 Reset: hold rst_i=0 for 5 cycles -> ack_o=0, next_o=0, dat_o=0, tid_o=0.
REQ-036 Classic write then read:
- Write adr 0x00100, sel=FFFF, dat=0x0123..CDEF, tid=5 -> ack_o=1 on the next cycle, tid_o=5.
- Read 0x00100 -> dat_o=0x0123..CDEF with ack_o.
REQ-037 Byte enables:
- Write all-ones to 0x00200, then write dat=0 with sel=0x00FF.
- Read 0x00200 -> upper 64 bits all ones, lower 64 bits zero.
REQ-038 Address aliasing: write 0x00304, then read 0x0030C -> same line returned.
REQ-039 Wrap: write 0x3FFF0, then read 0x7FFF0 with ADR_W=18 bits -> equal (upper bits out of range).
REQ-040 Burst (SCRATCHMEM_BURST_EN): 4-beat read from 0x01000 with cti 010,010,010,111 ->
- ack_o high for 4 cycles with lines 0x100..0x103;
- next_o=1 for the first 3 beats and 0 on the last;
- ack_o=0 on the following cycle.

Source files
------------

// File: rtl/scratch_mem128.sv
// 256 KiB single-port scratch memory (128-bit lines) on a Wishbone-style bus, byte enables, ID echo.
// Define SCRATCHMEM_BURST_EN to enable incrementing bursts (cti 010 / 111); otherwise every transfer is classic.
module scratch_mem128 #(
  parameter int ADR_W = 18,
  parameter int TID_W = 13
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cs_i,
  input  logic               cyc_i,
  input  logic               stb_i,
  input  logic               we_i,
  input  logic [2:0]         cti_i,
  input  logic [15:0]        sel_i,
  input  logic [ADR_W-1:0]   adr_i,
  input  logic [127:0]       dat_i,
  input  logic [TID_W-1:0]   tid_i,
  input  logic [31:0]        ip,
  input  logic [31:0]        sp,
  output logic [127:0]       dat_o,
  output logic               ack_o,
  output logic               next_o,
  output logic [TID_W-1:0]   tid_o,
  output logic [1:0]         fsm_state
);

  localparam int LINE_W = ADR_W - 4;
  localparam int DEPTH  = 1 << LINE_W;

  // Handshake: a request (cs&cyc&stb) is accepted only while ack_o is low; ack_o then rises the
  // next cycle and follows the request until it drops. In a burst each further request cycle is a beat.
  typedef enum logic [1:0] {S_IDLE, S_ACK, S_BURST, S_LAST} state_t;

  state_t              state;
  logic [127:0]        mem [DEPTH];
  logic [LINE_W-1:0]   burst_line;
  logic [LINE_W-1:0]   acc_line;
  logic                req;
  logic                accept;
  logic                beat;
  logic                access;
  logic                unused_bits;

  assign req    = cs_i & cyc_i & stb_i;
  assign accept = req & (state == S_IDLE);
`ifdef SCRATCHMEM_BURST_EN
  assign beat   = req & (state == S_BURST);
`else
  assign beat   = 1'b0;
`endif
  // Gate with reset so a request held during reset never touches the array.
  assign access    = (accept | beat) & rst_i;
  assign acc_line  = beat ? burst_line : adr_i[ADR_W-1:4];
  assign fsm_state = state;
  assign unused_bits = ^{ip, sp, cti_i, adr_i[3:0]};

  always_ff @(posedge clk_i) begin
    if (access && we_i) begin
      for (int n = 0; n < 16; n++) begin
        if (sel_i[n]) mem[acc_line][8*n +: 8] <= dat_i[8*n +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= S_IDLE;
      ack_o      <= 1'b0;
      next_o     <= 1'b0;
      tid_o      <= '0;
      dat_o      <= '0;
      burst_line <= '0;
    end else begin
      if (access && !we_i) dat_o <= mem[acc_line];
      case (state)
        S_IDLE: begin
          if (accept) begin
            ack_o      <= 1'b1;
            tid_o      <= tid_i;
            burst_line <= acc_line + LINE_W'(1);
`ifdef SCRATCHMEM_BURST_EN
            if (cti_i == 3'b010) begin
              state  <= S_BURST;
              next_o <= 1'b1;
            end else begin
              state  <= S_ACK;
            end
`else
            state <= S_ACK;
`endif
          end
        end
        S_ACK: begin
          if (!req) begin
            state <= S_IDLE;
            ack_o <= 1'b0;
          end
        end
        S_BURST: begin
          if (!req) begin
            state  <= S_IDLE;
            ack_o  <= 1'b0;
            next_o <= 1'b0;
          end else begin
            burst_line <= burst_line + LINE_W'(1);
            // Any cycle type other than "incrementing" closes the burst after this beat.
            if (cti_i != 3'b010) begin
              state  <= S_LAST;
              next_o <= 1'b0;
            end
          end
        end
        S_LAST: begin
          state <= S_IDLE;
          ack_o <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          ack_o  <= 1'b0;
          next_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scratch_mem128.sv
// Bench for scratch_mem128: directed vector table, reset/abort/hold sequences, burst (or classic
// fallback) sequence, then randomized traffic against a line-level reference memory.
module tb_scratch_mem128;
  localparam int ADR_W = 18;
  localparam int TID_W = 13;

  logic               clk = 1'b0;
  logic               rst_i = 1'b0;
  logic               cs_i = 1'b0, cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
  logic [2:0]         cti_i = '0;
  logic [15:0]        sel_i = '0;
  logic [ADR_W-1:0]   adr_i = '0;
  logic [127:0]       dat_i = '0;
  logic [TID_W-1:0]   tid_i = '0;
  logic [31:0]        ip = '0, sp = '0;
  logic [127:0]       dat_o;
  logic               ack_o, next_o;
  logic [TID_W-1:0]   tid_o;
  logic [1:0]         fsm_state;

  scratch_mem128 #(.ADR_W(ADR_W), .TID_W(TID_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .cs_i(cs_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .cti_i(cti_i), .sel_i(sel_i), .adr_i(adr_i), .dat_i(dat_i), .tid_i(tid_i),
    .ip(ip), .sp(sp), .dat_o(dat_o), .ack_o(ack_o), .next_o(next_o), .tid_o(tid_o),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic         w;
    logic [19:0]  adr;
    logic [15:0]  sel;
    logic [127:0] dat;
    logic [12:0]  tid;
    logic [127:0] exp_rd;
  } vec_t;

  localparam logic [127:0] C1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] C2 = 128'hA5A5A5A55A5A5A5ADEADBEEFCAFEF00D;
  localparam logic [127:0] C3 = 128'h11112222333344445555666677778888;
  localparam logic [127:0] C4 = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
  localparam logic [127:0] C5 = 128'hAABBCCDDEEFF00112233445566778899;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [127:0] ref_line [int];
  logic [127:0] exp_q [$];
  logic [127:0] last_rd = '0;
  vec_t         vecs [14];
  int           pool [8];
  int           line;
  logic [19:0]  a;
  logic [127:0] rd;

  function automatic int line_of(logic [19:0] adr);
    return int'(adr % 20'h40000) / 16;
  endfunction

  function automatic void model_write(logic [19:0] adr, logic [15:0] s, logic [127:0] d);
    int l;
    logic [127:0] v;
    l = line_of(adr);
    v = ref_line.exists(l) ? ref_line[l] : '0;
    for (int n = 0; n < 16; n++) if (s[n]) v[8*n +: 8] = d[8*n +: 8];
    ref_line[l] = v;
  endfunction

  function automatic void check(string nm, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  task automatic idle_bus();
    cs_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; cti_i = 3'b000;
  endtask

  task automatic req_on(input logic w, input logic [19:0] adr, input logic [15:0] s,
                        input logic [127:0] d, input logic [12:0] t, input logic [2:0] c);
    cs_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1; we_i = w; adr_i = adr[17:0];
    sel_i = s; dat_i = d; tid_i = t; cti_i = c;
  endtask

  // Classic single transfer, entered and left on a falling edge.
  task automatic xfer(input logic w, input logic [19:0] adr, input logic [15:0] s,
                      input logic [127:0] d, input logic [12:0] t, input logic [127:0] exp_rd,
                      input string nm);
    logic [127:0] e;
    if (!w) exp_q.push_back(exp_rd);
    req_on(w, adr, s, d, t, 3'b000);
    @(negedge clk);
    check({nm, ".ack"}, 128'(ack_o), 128'd1);
    check({nm, ".tid"}, 128'(tid_o), 128'(t));
    check({nm, ".next"}, 128'(next_o), 128'd0);
    if (!w) begin
      e = exp_q.pop_front();
      check({nm, ".rdata"}, dat_o, e);
      last_rd = e;
    end else begin
      check({nm, ".hold"}, dat_o, last_rd);
      model_write(adr, s, d);
    end
    idle_bus();
    @(negedge clk);
    check({nm, ".ack_clr"}, 128'(ack_o), 128'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 20'h00100, 16'hFFFF, C1,    13'd5,  '0};
    vecs[1]  = '{1'b0, 20'h00100, 16'h0000, '0,    13'd6,  C1};
    vecs[2]  = '{1'b1, 20'h00200, 16'hFFFF, '1,    13'd7,  '0};
    vecs[3]  = '{1'b1, 20'h00200, 16'h00FF, '0,    13'd8,  '0};
    vecs[4]  = '{1'b0, 20'h00200, 16'h0000, '0,    13'd9,  {64'hFFFFFFFFFFFFFFFF, 64'h0}};
    vecs[5]  = '{1'b1, 20'h00304, 16'hFFFF, C2,    13'd10, '0};
    vecs[6]  = '{1'b0, 20'h0030C, 16'h0000, '0,    13'd11, C2};
    vecs[7]  = '{1'b1, 20'h3FFF0, 16'hFFFF, C3,    13'd12, '0};
    vecs[8]  = '{1'b0, 20'h7FFF0, 16'h0000, '0,    13'd13, C3};
    vecs[9]  = '{1'b1, 20'h00400, 16'hFFFF, C4,    13'd14, '0};
    vecs[10] = '{1'b1, 20'h00400, 16'h0000, C5,    13'd15, '0};
    vecs[11] = '{1'b0, 20'h00400, 16'h0000, '0,    13'd16, C4};
    vecs[12] = '{1'b1, 20'h00400, 16'h8001, C5,    13'd17, '0};
    vecs[13] = '{1'b0, 20'h00400, 16'h0000, '0,    13'd18, 128'hAA1E2D3C4B5A69788796A5B4C3D2E199};

    // Reset held for five cycles.
    idle_bus();
    rst_i = 1'b0;
    repeat (5) @(negedge clk);
    check("rst.ack", 128'(ack_o), 128'd0);
    check("rst.next", 128'(next_o), 128'd0);
    check("rst.dat", dat_o, 128'd0);
    check("rst.tid", 128'(tid_o), 128'd0);

    // Request pending across reset release: accepted on the first edge after release.
    req_on(1'b1, 20'h00500, 16'hFFFF, C5, 13'd3, 3'b000);
    @(negedge clk);
    check("rst_req.ack", 128'(ack_o), 128'd0);
    rst_i = 1'b1;
    @(negedge clk);
    check("first_acc.ack", 128'(ack_o), 128'd1);
    check("first_acc.tid", 128'(tid_o), 128'd3);
    model_write(20'h00500, 16'hFFFF, C5);
    idle_bus();
    @(negedge clk);
    check("first_acc.ack_clr", 128'(ack_o), 128'd0);
    xfer(1'b0, 20'h00500, '0, '0, 13'd4, C5, "first_acc_rd");

    foreach (vecs[i]) begin
      xfer(vecs[i].w, vecs[i].adr, vecs[i].sel, vecs[i].dat, vecs[i].tid, vecs[i].exp_rd,
           $sformatf("vec%0d", i));
    end

    // Request held after ack: ack stays, no second access even if it turns into a write.
    req_on(1'b0, 20'h00100, 16'hFFFF, '0, 13'd30, 3'b000);
    @(negedge clk);
    check("hold.ack0", 128'(ack_o), 128'd1);
    check("hold.dat0", dat_o, C1);
    we_i = 1'b1; dat_i = ~C1; tid_i = 13'd31;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("hold.ack%0d", k + 1), 128'(ack_o), 128'd1);
      check($sformatf("hold.tid%0d", k + 1), 128'(tid_o), 128'd30);
    end
    idle_bus();
    @(negedge clk);
    check("hold.ack_clr", 128'(ack_o), 128'd0);
    last_rd = C1;
    xfer(1'b0, 20'h00100, '0, '0, 13'd32, C1, "hold_rd");

    // Reset during the ack of an accepted write: the write lands, later requests in reset do not.
    xfer(1'b1, 20'h00700, 16'hFFFF, C2, 13'd20, '0, "pre_abort");
    req_on(1'b1, 20'h00700, 16'hFFFF, C3, 13'd21, 3'b000);
    @(posedge clk);
    #2 rst_i = 1'b0;
    #1;
    check("abort.ack", 128'(ack_o), 128'd0);
    check("abort.tid", 128'(tid_o), 128'd0);
    check("abort.dat", dat_o, 128'd0);
    model_write(20'h00700, 16'hFFFF, C3);
    dat_i = C4;
    @(negedge clk);
    @(negedge clk);
    idle_bus();
    rst_i = 1'b1;
    last_rd = '0;
    @(negedge clk);
    xfer(1'b0, 20'h00700, '0, '0, 13'd22, C3, "abort_rd");

    for (int k = 0; k < 4; k++) begin
      xfer(1'b1, 20'(20'h01000 + 16 * k), 16'hFFFF, {$urandom, $urandom, $urandom, $urandom},
           13'(40 + k), '0, $sformatf("pre_burst%0d", k));
    end
`ifdef SCRATCHMEM_BURST_EN
    // Four-beat read burst from line 0x100; adr_i is left at the start address throughout.
    req_on(1'b0, 20'h01000, '0, '0, 13'd50, 3'b010);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("burst_rd%0d.ack", k), 128'(ack_o), 128'd1);
      check($sformatf("burst_rd%0d.dat", k), dat_o, ref_line[256 + k]);
      check($sformatf("burst_rd%0d.next", k), 128'(next_o), (k < 3) ? 128'd1 : 128'd0);
      check($sformatf("burst_rd%0d.tid", k), 128'(tid_o), 128'd50);
      if (k < 3) cti_i = (k == 2) ? 3'b111 : 3'b010;
    end
    @(negedge clk);
    check("burst_rd.ack_clr", 128'(ack_o), 128'd0);
    check("burst_rd.next_clr", 128'(next_o), 128'd0);
    idle_bus();
    last_rd = ref_line[259];
    @(negedge clk);

    // Two-beat write burst wrapping from the top line to line 0, per-beat byte enables.
    xfer(1'b1, 20'h3FFF0, 16'hFFFF, {4{$urandom}}, 13'd51, '0, "pre_wrap_top");
    xfer(1'b1, 20'h00000, 16'hFFFF, {4{$urandom}}, 13'd52, '0, "pre_wrap_zero");
    req_on(1'b1, 20'h3FFF0, 16'hFFFF, C4, 13'd53, 3'b010);
    @(negedge clk);
    check("burst_wr0.ack", 128'(ack_o), 128'd1);
    check("burst_wr0.next", 128'(next_o), 128'd1);
    model_write(20'h3FFF0, 16'hFFFF, C4);
    sel_i = 16'h00F0; dat_i = C5; cti_i = 3'b111;
    @(negedge clk);
    check("burst_wr1.ack", 128'(ack_o), 128'd1);
    check("burst_wr1.next", 128'(next_o), 128'd0);
    model_write(20'h40000, 16'h00F0, C5);
    idle_bus();
    @(negedge clk);
    check("burst_wr.ack_clr", 128'(ack_o), 128'd0);
    xfer(1'b0, 20'h3FFF0, '0, '0, 13'd54, ref_line[line_of(20'h3FFF0)], "wrap_rd_top");
    xfer(1'b0, 20'h00000, '0, '0, 13'd55, ref_line[0], "wrap_rd_zero");
`else
    // Without burst support cti 010 is a classic transfer: no advance, next_o stays low.
    req_on(1'b0, 20'h01000, '0, '0, 13'd50, 3'b010);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("nob%0d.ack", k), 128'(ack_o), 128'd1);
      check($sformatf("nob%0d.dat", k), dat_o, ref_line[256]);
      check($sformatf("nob%0d.next", k), 128'(next_o), 128'd0);
    end
    idle_bus();
    @(negedge clk);
    check("nob.ack_clr", 128'(ack_o), 128'd0);
    last_rd = ref_line[256];
`endif

    // Random traffic over a small pool of fully initialised lines.
    for (int i = 0; i < 8; i++) begin
      pool[i] = $urandom_range(0, 16383);
      xfer(1'b1, 20'(pool[i] * 16), 16'hFFFF, {$urandom, $urandom, $urandom, $urandom},
           13'($urandom), '0, $sformatf("rnd_init%0d", i));
    end
    for (int it = 0; it < 80; it++) begin
      line = pool[$urandom_range(0, 7)];
      a = 20'(line * 16 + $urandom_range(0, 15) + ($urandom_range(0, 3) << 18));
      if ($urandom_range(0, 1) == 1) begin
        xfer(1'b1, a, 16'($urandom), {$urandom, $urandom, $urandom, $urandom}, 13'($urandom),
             '0, $sformatf("rnd%0d_wr", it));
      end else begin
        rd = ref_line[line_of(a)];
        xfer(1'b0, a, 16'($urandom), '0, 13'($urandom), rd, $sformatf("rnd%0d_rd", it));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
